// File: rtl/dmem_responder.sv
// Data-memory responder: single-port RAM with one-cycle read latency, plus a
// 16-byte MMIO window holding the tohost mailbox and a free-running 64-bit timer.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter logic [63:0] CNT_INIT  = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic        dmem_wen_i,
  input  logic [3:0]  dmem_ben_i,
  output logic [31:0] dmem_rdata_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        err_o
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  logic [31:0]   mem [MEM_WORDS];
  logic [63:0]   timer;
  logic [31:0]   off;
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] idx;
  logic          any_ben;
  logic          ram_we;
  logic          tohost_we;
  logic [31:0]   rd_next;
  logic          err_next;

  // The wrapped subtraction makes addresses below MEM_BASE look huge, so a
  // single unsigned compare covers both bounds of the RAM window.
  always_comb begin
    off       = dmem_addr_i - MEM_BASE;
    ram_hit   = {1'b0, off} < MEM_BYTES;
    mmio_hit  = !ram_hit && (dmem_addr_i[31:4] == MMIO_BASE[31:4]);
    idx       = off[AW+1:2];
    any_ben   = |dmem_ben_i;
    ram_we    = !rst_i && ram_hit && dmem_wen_i;
    tohost_we = !rst_i && mmio_hit && (dmem_addr_i[3:2] == 2'd0) && dmem_wen_i && any_ben;
    rd_next   = 32'd0;
    if (ram_hit) begin
      rd_next = mem[idx];
    end else if (mmio_hit) begin
      case (dmem_addr_i[3:2])
        2'd0:    rd_next = tohost_data_o;
        2'd1:    rd_next = timer[31:0];
        2'd2:    rd_next = timer[63:32];
        default: rd_next = 32'd0;
      endcase
    end
    // Unaligned idle load addresses must not raise err.
    err_next = !ram_hit && !mmio_hit &&
               ((dmem_wen_i && any_ben) || (!dmem_wen_i && (dmem_addr_i[1:0] == 2'b00)));
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_ben_i[i]) mem[idx][8*i +: 8] <= dmem_wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_rdata_o   <= 32'd0;
      tohost_valid_o <= 1'b0;
      tohost_data_o  <= 32'd0;
      err_o          <= 1'b0;
      timer          <= CNT_INIT;
    end else begin
      dmem_rdata_o <= rd_next;
      err_o        <= err_next;
      timer        <= timer + 64'd1;
      if (tohost_we) begin
        tohost_valid_o <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (dmem_ben_i[i]) tohost_data_o[8*i +: 8] <= dmem_wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory interface: a single-port RAM answering the core's dmem_addr/dmem_wdata/dmem_wen/dmem_ben outputs with dmem_rdata.
- Adds a small MMIO window with a tohost mailbox and a free-running 64-bit cycle timer.
- Serves simulation benches and the FPGA top. Replaces the randomised dmem_rdata source outside formal runs.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words; power of two, at least 16.
- MEM_BASE, 32'h0000_0000, byte base address of the RAM; aligned to MEM_WORDS*4.
- MMIO_BASE, 32'h8000_0000, byte base of the MMIO window (16 bytes).
- CNT_INIT, 64'd0, cycle-timer value loaded at reset; benches use it for wrap tests.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- dmem_addr_i  in  32  byte address from core; sampled every cycle.
- dmem_wdata_i  in  32  store data; lanes are already positioned by the core.
- dmem_wen_i  in  1  store strobe.
- dmem_ben_i  in  4  byte enables; bit i enables wdata[8i+7:8i].
- dmem_rdata_o  out  32  load data for the address sampled in the previous cycle.
- tohost_valid_o  out  1  sticky flag, set by any store to the tohost register.
- tohost_data_o  out  32  last value written to tohost.
- err_o  out  1  one-cycle pulse on an access outside RAM and MMIO.

Behaviour:
- Reset values when rst_i=1 at a clock edge:
  - dmem_rdata_o=0, tohost_valid_o=0, tohost_data_o=0, err_o=0.
  - Timer is loaded with CNT_INIT.
  - RAM contents are not reset.
  - Writes presented in a reset cycle are dropped.
- Address decode uses the full 32-bit address:
  - RAM hit: MEM_BASE <= addr < MEM_BASE+MEM_WORDS*4. Word index = (addr-MEM_BASE)[log2(MEM_WORDS)+1:2]; addr[1:0] is ignored.
  - MMIO hit: addr[31:4]==MMIO_BASE[31:4]. Offsets: 0x0 TOHOST, 0x4 TIME_LO, 0x8 TIME_HI, 0xC reserved.
  - Anything else is a miss.
- Reads:
  - Performed every cycle. Exactly one cycle of latency: dmem_rdata_o at edge N+1 reflects dmem_addr_i at edge N.
  - RAM hit returns the full 32-bit word. The core extracts bytes and halfwords.
  - TOHOST returns tohost_data_o. TIME_LO/TIME_HI return timer[31:0] / timer[63:32] as of edge N. No atomic snapshot: software rereads HI.
  - Offset 0xC and misses read 0.
- Writes (dmem_wen_i=1 at edge N):
  - RAM: each byte with ben[i]=1 is updated. Visible to reads sampled at edge N+1 or later.
  - Read and write to the same word in the same cycle is read-first: rdata returns pre-write data.
  - TOHOST: bytes with ben set are merged into tohost_data_o; tohost_valid_o=1 from edge N+1 until reset. A later write updates the data; valid stays 1.
  - TIME_LO, TIME_HI and 0xC are read-only; writes are dropped without error.
  - wen=1 with ben=0: no state change and no error.
- err_o:
  - Pulses high for exactly one cycle (edge N+1) for a miss at edge N with wen=1 and ben!=0.
  - Also pulses for a miss on the load path, but only when wen=0 and the address is 4-byte aligned. This keeps err from firing while the core's address bus is idle and unaligned.
  - Back-to-back misses hold err_o high on consecutive cycles.
- Timer:
  - Increments by 1 every non-reset cycle.
  - Wraps 2^64-1 -> 0 silently.

Test Plan:
- Store 32'hDEAD_BEEF to MEM_BASE+0x10 with ben=4'hF, then load the same address -> rdata=32'hDEAD_BEEF one cycle after the load address is presented.
- Preload 32'h1122_3344 at word 5, store 32'hAABB_CCDD with ben=4'b0101 -> subsequent read returns 32'h11BB_33DD.
- In one cycle, present addr=word 7 (old 32'h0) with wen=1, wdata=32'hFFFF_FFFF -> rdata next cycle=0; following cycle=32'hFFFF_FFFF.
- Store 32'h1 to MMIO_BASE -> tohost_valid_o=1 next cycle, tohost_data_o=1. Then store to MEM_BASE+MEM_WORDS*4 -> err_o high for exactly one cycle, RAM unchanged.
- CNT_INIT=64'hFFFF_FFFF_FFFF_FFFE; read TIME_LO on cycles 0..3 after reset -> FFFF_FFFE, FFFF_FFFF, 0, 1. Read TIME_HI after the wrap -> 0.
- Assert rst_i mid-sequence while wen=1 to TOHOST -> tohost_valid_o=0, rdata=0, err_o=0. Write is dropped, and RAM data written before reset still reads back unchanged.
